// File: rtl/sdio_cmd_sequencer_pkg.sv
// Shared definitions for the SDIO command sequencer: command indices, R5 flag
// positions, card/FSM state encodings and command-argument field positions.
package sdio_defines;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD3  = 6'd3;
  localparam logic [5:0] CMD5  = 6'd5;
  localparam logic [5:0] CMD7  = 6'd7;
  localparam logic [5:0] CMD52 = 6'd52;
  localparam logic [5:0] CMD53 = 6'd53;

  localparam logic [7:0] RSPS_LEN = 8'd39;

  localparam int unsigned R5_COM_CRC_ERR  = 7;
  localparam int unsigned R5_ILLEGAL      = 6;
  localparam int unsigned R5_IO_STATE_HI  = 5;
  localparam int unsigned R5_IO_STATE_LO  = 4;
  localparam int unsigned R5_ERROR        = 3;
  localparam int unsigned R5_FUNC_NUM     = 1;
  localparam int unsigned R5_OUT_OF_RANGE = 0;

  localparam int unsigned ARG_RW       = 31;
  localparam int unsigned ARG_FUNC_HI  = 30;
  localparam int unsigned ARG_FUNC_LO  = 28;
  localparam int unsigned ARG_RAW_BLK  = 27;
  localparam int unsigned ARG_ADDR_HI  = 25;
  localparam int unsigned ARG_ADDR_LO  = 9;
  localparam int unsigned ARG_RCA_HI   = 31;
  localparam int unsigned ARG_RCA_LO   = 16;
  localparam int unsigned ARG_CNT_HI   = 8;
  localparam int unsigned ARG_WDATA_HI = 7;

  typedef enum logic [1:0] {
    CARD_INIT = 2'b00,
    CARD_STBY = 2'b01,
    CARD_CMD  = 2'b10,
    CARD_TRN  = 2'b11
  } card_state_e;

  typedef enum logic [1:0] {
    RSP_R4,
    RSP_R6,
    RSP_R1B,
    RSP_R5
  } rsp_kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_REG_ACC,
    S_RSPS,
    S_XFER
  } seq_state_e;

  // RCA 0 is reserved, so the issued sequence wraps straight to 1
  function automatic logic [15:0] next_rca(input logic [15:0] rca);
    logic [15:0] n;
    n = rca + 16'd1;
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

  function automatic logic [1:0] io_state(input card_state_e c);
    case (c)
      CARD_CMD: return 2'b01;
      CARD_TRN: return 2'b10;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/sdio_cmd_sequencer_rsps_builder.sv
// Combinational assembly of the 40-bit response frame from response kind and fields.
module sdio_rsps_builder
  import sdio_defines::*;
#(
  parameter int unsigned NUM_FUNCS = 1,
  parameter logic [23:0] OCR       = 24'hFF8000
) (
  input  logic [5:0]  index_i,
  input  logic [1:0]  kind_i,
  input  logic [15:0] rca_i,
  input  logic [1:0]  card_state_i,
  input  logic [7:0]  flags_i,
  input  logic [7:0]  data_i,
  output logic [39:0] rsps_o
);

  localparam logic [2:0] NF = 3'(NUM_FUNCS);

  logic [31:0] payload;

  always_comb begin
    payload = '0;
    case (kind_i)
      RSP_R4:  payload = {1'b1, NF, 1'b0, 3'b000, OCR};
      RSP_R6:  payload = {rca_i, 16'h0000};
      // Card status carries current_state in bits [12:9]
      RSP_R1B: payload = {19'h0, 2'b00, card_state_i, 9'h0};
      default: payload = {16'h0000, flags_i, data_i};
    endcase
  end

  assign rsps_o = {1'b0, index_i, payload, 1'b0};

endmodule

// File: rtl/sdio_cmd_sequencer.sv
// SDIO command-layer sequencer: decodes commands, tracks card state/RCA, runs CMD52/53.
// Optional register-ack timeout enabled by defining SDIO_CMD_REG_TIMEOUT_EN.
module sdio_cmd_sequencer
  import sdio_defines::*;
#(
  parameter int unsigned NUM_FUNCS   = 1,
  parameter logic [23:0] OCR         = 24'hFF8000,
  parameter logic [15:0] RCA_SEED    = 16'h0001,
  parameter int unsigned REG_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  input  logic        i_cmd_crc_good_stb,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_arg,
  output logic        o_rsps_stb,
  output logic [39:0] o_rsps,
  output logic [7:0]  o_rsps_len,
  output logic        o_rsps_fail,
  output logic        o_reg_req,
  output logic        o_reg_wr,
  output logic [2:0]  o_reg_func,
  output logic [16:0] o_reg_addr,
  output logic [7:0]  o_reg_wdata,
  input  logic        i_reg_ack,
  input  logic [7:0]  i_reg_rdata,
  output logic        o_data_activate,
  output logic        o_write_flag,
  output logic [12:0] o_data_count,
  input  logic        i_data_done,
  output logic [1:0]  o_card_state
);

  localparam logic [2:0] NF = 3'(NUM_FUNCS);

  if (NUM_FUNCS < 1 || NUM_FUNCS > 7 || REG_TIMEOUT < 1) begin : g_bad_params
    $error("sdio_cmd_sequencer: parameter out of range");
  end

  seq_state_e  state_q, state_d;
  card_state_e card_q, card_d;
  logic [15:0] rca_q, rca_d, nxt_rca_q, nxt_rca_d;
  logic [5:0]  cmd_q;
  logic [31:0] arg_q;
  logic        crc_ok_q;
  logic        crc_err_q, crc_err_d, illegal_q, illegal_d;
  logic        fail_q, fail_d, xfer_q, xfer_d;
  logic [39:0] rsps_q, rsps_d;

  rsp_kind_e   b_kind;
  logic [15:0] b_rca;
  logic        b_err, b_fnum;
  logic [7:0]  b_data, b_flags;
  logic [39:0] b_rsps;
  logic        load, bad;

`ifdef SDIO_CMD_REG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(REG_TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= (state_q == S_REG_ACC) ? to_cnt_q + 1'b1 : '0;
  end
`endif

  assign b_flags = {crc_err_q, illegal_q, io_state(card_q), b_err, 1'b0, b_fnum, 1'b0};

  sdio_rsps_builder #(.NUM_FUNCS(NUM_FUNCS), .OCR(OCR)) u_builder (
    .index_i      (cmd_q),
    .kind_i       (b_kind),
    .rca_i        (b_rca),
    .card_state_i (card_q),
    .flags_i      (b_flags),
    .data_i       (b_data),
    .rsps_o       (b_rsps)
  );

  always_comb begin
    state_d   = state_q;
    card_d    = card_q;
    rca_d     = rca_q;
    nxt_rca_d = nxt_rca_q;
    crc_err_d = crc_err_q;
    illegal_d = illegal_q;
    fail_d    = 1'b0;
    xfer_d    = xfer_q;
    rsps_d    = rsps_q;
    b_kind    = RSP_R5;
    b_rca     = rca_q;
    b_err     = 1'b0;
    b_fnum    = 1'b0;
    b_data    = '0;
    load      = 1'b0;
    bad       = 1'b0;
    case (state_q)
      S_IDLE: begin
        xfer_d = 1'b0;
        if (i_cmd_stb) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (!crc_ok_q) begin
          fail_d    = 1'b1;
          crc_err_d = 1'b1;
        end else begin
          case (cmd_q)
            CMD0: begin
              card_d = CARD_INIT;
              fail_d = 1'b1;
            end
            CMD5: begin
              if (card_q == CARD_INIT || card_q == CARD_STBY) begin
                b_kind = RSP_R4;
                load   = 1'b1;
              end else bad = 1'b1;
            end
            CMD3: begin
              if (card_q == CARD_INIT || card_q == CARD_STBY) begin
                b_kind    = RSP_R6;
                b_rca     = nxt_rca_q;
                rca_d     = nxt_rca_q;
                nxt_rca_d = next_rca(nxt_rca_q);
                card_d    = CARD_STBY;
                load      = 1'b1;
              end else bad = 1'b1;
            end
            CMD7: begin
              if (arg_q[ARG_RCA_HI:ARG_RCA_LO] == rca_q) begin
                b_kind = RSP_R1B;
                card_d = CARD_CMD;
                load   = 1'b1;
              end else begin
                card_d = CARD_STBY;
                fail_d = 1'b1;
              end
            end
            CMD52, CMD53: begin
              if (card_q != CARD_CMD && card_q != CARD_TRN) bad = 1'b1;
              else if (arg_q[ARG_FUNC_HI:ARG_FUNC_LO] > NF) begin
                b_fnum = 1'b1;
                load   = 1'b1;
              end else if (cmd_q == CMD53 && arg_q[ARG_RAW_BLK]) begin
                b_err = 1'b1;
                load  = 1'b1;
              end else if (cmd_q == CMD52) begin
                state_d = S_REG_ACC;
              end else begin
                xfer_d = 1'b1;
                load   = 1'b1;
              end
            end
            default: bad = 1'b1;
          endcase
        end
        if (bad) begin
          fail_d    = 1'b1;
          illegal_d = 1'b1;
        end
      end
      S_REG_ACC: begin
        // A RAW write reports the value read back after the write
        if (i_reg_ack) begin
          b_data = (arg_q[ARG_RW] && !arg_q[ARG_RAW_BLK]) ? arg_q[ARG_WDATA_HI:0] : i_reg_rdata;
          load   = 1'b1;
        end
`ifdef SDIO_CMD_REG_TIMEOUT_EN
        else if (to_cnt_q == TW'(REG_TIMEOUT - 1)) begin
          b_err = 1'b1;
          load  = 1'b1;
        end
`endif
      end
      S_RSPS: begin
        if (xfer_q) begin
          state_d = S_XFER;
          card_d  = CARD_TRN;
        end else state_d = S_IDLE;
      end
      S_XFER: begin
        if (i_data_done) begin
          state_d = S_IDLE;
          card_d  = CARD_CMD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      rsps_d  = b_rsps;
      state_d = S_RSPS;
      if (b_kind == RSP_R5) begin
        crc_err_d = 1'b0;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      card_q    <= CARD_INIT;
      rca_q     <= RCA_SEED;
      nxt_rca_q <= RCA_SEED;
      cmd_q     <= '0;
      arg_q     <= '0;
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      illegal_q <= 1'b0;
      fail_q    <= 1'b0;
      xfer_q    <= 1'b0;
      rsps_q    <= '0;
    end else begin
      state_q   <= state_d;
      card_q    <= card_d;
      rca_q     <= rca_d;
      nxt_rca_q <= nxt_rca_d;
      crc_err_q <= crc_err_d;
      illegal_q <= illegal_d;
      fail_q    <= fail_d;
      xfer_q    <= xfer_d;
      rsps_q    <= rsps_d;
      if (state_q == S_IDLE && i_cmd_stb) begin
        cmd_q    <= i_cmd;
        arg_q    <= i_cmd_arg;
        crc_ok_q <= i_cmd_crc_good_stb;
      end
    end
  end

  assign o_rsps_stb      = (state_q == S_RSPS);
  assign o_rsps          = rsps_q;
  assign o_rsps_len      = RSPS_LEN;
  assign o_rsps_fail     = fail_q;
  assign o_reg_req       = (state_q == S_REG_ACC);
  assign o_reg_wr        = o_reg_req & arg_q[ARG_RW];
  assign o_reg_func      = {3{o_reg_req}} & arg_q[ARG_FUNC_HI:ARG_FUNC_LO];
  assign o_reg_addr      = {17{o_reg_req}} & arg_q[ARG_ADDR_HI:ARG_ADDR_LO];
  assign o_reg_wdata     = {8{o_reg_req}} & arg_q[ARG_WDATA_HI:0];
  assign o_data_activate = (state_q == S_XFER);
  assign o_write_flag    = o_data_activate & arg_q[ARG_RW];
  assign o_data_count    = !o_data_activate ? 13'd0 :
                           (arg_q[ARG_CNT_HI:0] == 9'd0) ? 13'd512 : {4'b0000, arg_q[ARG_CNT_HI:0]};
  assign o_card_state    = card_q;

endmodule

// File: tb/tb_sdio_cmd_sequencer.sv
// Directed self-checking bench for sdio_cmd_sequencer (timeout case under SDIO_CMD_REG_TIMEOUT_EN).
module tb_sdio_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_stb, i_cmd_crc_good_stb;
  logic [5:0]  i_cmd;
  logic [31:0] i_cmd_arg;
  logic        o_rsps_stb, o_rsps_fail;
  logic [39:0] o_rsps;
  logic [7:0]  o_rsps_len;
  logic        o_reg_req, o_reg_wr;
  logic [2:0]  o_reg_func;
  logic [16:0] o_reg_addr;
  logic [7:0]  o_reg_wdata;
  logic        i_reg_ack = 1'b0;
  logic [7:0]  i_reg_rdata = 8'h00;
  logic        o_data_activate, o_write_flag;
  logic [12:0] o_data_count;
  logic        i_data_done;
  logic [1:0]  o_card_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdio_cmd_sequencer #(
    .NUM_FUNCS (1),
    .OCR       (24'hFF8000),
    .RCA_SEED  (16'h0001)
`ifdef SDIO_CMD_REG_TIMEOUT_EN
    , .REG_TIMEOUT (8)
`endif
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_cmd_stb          (i_cmd_stb),
    .i_cmd_crc_good_stb (i_cmd_crc_good_stb),
    .i_cmd              (i_cmd),
    .i_cmd_arg          (i_cmd_arg),
    .o_rsps_stb         (o_rsps_stb),
    .o_rsps             (o_rsps),
    .o_rsps_len         (o_rsps_len),
    .o_rsps_fail        (o_rsps_fail),
    .o_reg_req          (o_reg_req),
    .o_reg_wr           (o_reg_wr),
    .o_reg_func         (o_reg_func),
    .o_reg_addr         (o_reg_addr),
    .o_reg_wdata        (o_reg_wdata),
    .i_reg_ack          (i_reg_ack),
    .i_reg_rdata        (i_reg_rdata),
    .o_data_activate    (o_data_activate),
    .o_write_flag       (o_write_flag),
    .o_data_count       (o_data_count),
    .i_data_done        (i_data_done),
    .o_card_state       (o_card_state)
  );

  // Register-port responder: acks on the ack_after-th cycle of a request (0 = never)
  int          ack_after = 0;
  logic [7:0]  rd_val = 8'h00;
  int          req_cnt = 0, last_req_len = 0, req_total = 0;
  logic        snap_wr = 1'b0;
  logic [2:0]  snap_func = '0;
  logic [16:0] snap_addr = '0;
  logic [7:0]  snap_wdata = '0;

  always @(negedge clk) begin
    i_reg_ack = 1'b0;
    if (o_reg_req) begin
      req_cnt++;
      req_total++;
      snap_wr = o_reg_wr;
      snap_func = o_reg_func;
      snap_addr = o_reg_addr;
      snap_wdata = o_reg_wdata;
      if (ack_after != 0 && req_cnt == ack_after) begin
        i_reg_ack = 1'b1;
        i_reg_rdata = rd_val;
      end
    end else if (req_cnt != 0) begin
      last_req_len = req_cnt;
      req_cnt = 0;
    end
  end

  function automatic logic [39:0] frame(input logic [5:0] idx, input logic [31:0] payload);
    return {1'b0, idx, payload, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic crc,
                       output int lat, output logic stb, output logic fail, output logic [39:0] rsp);
    @(negedge clk);
    i_cmd = idx;
    i_cmd_arg = arg;
    i_cmd_crc_good_stb = crc;
    i_cmd_stb = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    i_cmd_crc_good_stb = 1'b0;
    lat = 1;
    stb = 1'b0;
    fail = 1'b0;
    rsp = '0;
    while (lat < 40) begin
      if (o_rsps_stb || o_rsps_fail) begin
        stb = o_rsps_stb;
        fail = o_rsps_fail;
        rsp = o_rsps;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input logic crc, input logic exp_stb, input int exp_lat,
                        input logic [39:0] exp_rsp);
    int lat;
    logic s, f;
    logic [39:0] r;
    issue(idx, arg, crc, lat, s, f, r);
    chk({tag, "_lat"}, 40'(lat), 40'(exp_lat));
    chk({tag, "_stb"}, 40'(s), 40'(exp_stb));
    chk({tag, "_fail"}, 40'(f), 40'(!exp_stb));
    if (exp_stb) chk({tag, "_rsps"}, r, exp_rsp);
    @(negedge clk);
    chk({tag, "_pulse"}, 40'({o_rsps_stb, o_rsps_fail}), 40'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rt;
    logic seen;
    rst = 1'b1;
    i_cmd_stb = 1'b0;
    i_cmd_crc_good_stb = 1'b0;
    i_cmd = '0;
    i_cmd_arg = '0;
    i_data_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 40'({o_rsps_stb, o_rsps_fail, o_reg_req, o_data_activate, o_write_flag}), 40'(0));
    chk("rst_rsps", o_rsps, 40'(0));
    chk("rst_len", 40'(o_rsps_len), 40'(39));
    chk("rst_card", 40'(o_card_state), 40'(0));
    chk("rst_count", 40'(o_data_count), 40'(0));
    rst = 1'b0;

    do_cmd("cmd5", 6'd5, 32'h0, 1'b1, 1'b1, 2, frame(6'd5, 32'h90FF8000));
    do_cmd("cmd52_init", 6'd52, 32'h0, 1'b1, 1'b0, 2, '0);
    chk("card_init", 40'(o_card_state), 40'(2'b00));
    do_cmd("cmd3", 6'd3, 32'h0, 1'b1, 1'b1, 2, frame(6'd3, 32'h0001_0000));
    chk("card_stby", 40'(o_card_state), 40'(2'b01));
    do_cmd("cmd7_bad", 6'd7, 32'h0002_0000, 1'b1, 1'b0, 2, '0);
    chk("card_stby2", 40'(o_card_state), 40'(2'b01));
    do_cmd("cmd7", 6'd7, 32'h0001_0000, 1'b1, 1'b1, 2, frame(6'd7, 32'h0000_0200));
    chk("card_cmd", 40'(o_card_state), 40'(2'b10));

    // Read func 1 addr 0x10; ILLEGAL from the earlier CMD52 is reported here
    ack_after = 5; rd_val = 8'hA5;
    do_cmd("rd52", 6'd52, 32'h1000_2000, 1'b1, 1'b1, 7, frame(6'd52, 32'h0000_50A5));
    chk("rd52_reqlen", 40'(last_req_len), 40'(5));
    chk("rd52_fields", 40'({snap_wr, snap_func, snap_addr}), 40'({1'b0, 3'd1, 17'h00010}));

    rt = req_total;
    do_cmd("crc52", 6'd52, 32'h1000_2000, 1'b0, 1'b0, 2, '0);
    chk("crc52_noreq", 40'(req_total), 40'(rt));

    ack_after = 1; rd_val = 8'h77;
    do_cmd("wr52", 6'd52, 32'h9000_403C, 1'b1, 1'b1, 3, frame(6'd52, 32'h0000_903C));
    chk("wr52_fields", 40'({snap_wr, snap_addr, snap_wdata}), 40'({1'b1, 17'h00020, 8'h3C}));

    ack_after = 2; rd_val = 8'h5A;
    do_cmd("raw52", 6'd52, 32'h9800_403C, 1'b1, 1'b1, 4, frame(6'd52, 32'h0000_105A));

    rt = req_total;
    do_cmd("func52", 6'd52, 32'h2000_0000, 1'b1, 1'b1, 2, frame(6'd52, 32'h0000_1200));
    chk("func52_noreq", 40'(req_total), 40'(rt));
    do_cmd("blk53", 6'd53, 32'h1800_0000, 1'b1, 1'b1, 2, frame(6'd53, 32'h0000_1800));
    chk("blk53_noact", 40'(o_data_activate), 40'(0));

    do_cmd("wr53", 6'd53, 32'h9000_0000, 1'b1, 1'b1, 2, frame(6'd53, 32'h0000_1000));
    chk("wr53_xfer", 40'({o_data_activate, o_write_flag, o_data_count, o_card_state}),
        40'({1'b1, 1'b1, 13'd512, 2'b11}));
    repeat (3) @(negedge clk);
    chk("wr53_hold", 40'(o_data_activate), 40'(1));
    i_data_done = 1'b1;
    @(negedge clk);
    i_data_done = 1'b0;
    chk("wr53_done", 40'({o_data_activate, o_card_state}), 40'({1'b0, 2'b10}));

    do_cmd("rd53", 6'd53, 32'h1000_0005, 1'b1, 1'b1, 2, frame(6'd53, 32'h0000_1000));
    chk("rd53_xfer", 40'({o_data_activate, o_write_flag, o_data_count}), 40'({1'b1, 1'b0, 13'd5}));
    i_cmd = 6'd5; i_cmd_arg = '0; i_cmd_crc_good_stb = 1'b1; i_cmd_stb = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0; i_cmd_crc_good_stb = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen = seen | o_rsps_stb | o_rsps_fail;
      @(negedge clk);
    end
    chk("xfer_ignore", 40'(seen), 40'(0));
    i_data_done = 1'b1;
    @(negedge clk);
    i_data_done = 1'b0;
    chk("rd53_done", 40'({o_data_activate, o_card_state}), 40'({1'b0, 2'b10}));

    do_cmd("cmd0", 6'd0, 32'h0, 1'b1, 1'b0, 2, '0);
    chk("cmd0_card", 40'(o_card_state), 40'(2'b00));
    do_cmd("cmd3b", 6'd3, 32'h0, 1'b1, 1'b1, 2, frame(6'd3, 32'h0002_0000));
    do_cmd("cmd7b", 6'd7, 32'h0002_0000, 1'b1, 1'b1, 2, frame(6'd7, 32'h0000_0200));

    ack_after = 0;
`ifdef SDIO_CMD_REG_TIMEOUT_EN
    do_cmd("tmo52", 6'd52, 32'h1000_2000, 1'b1, 1'b1, 10, frame(6'd52, 32'h0000_1800));
    chk("tmo52_reqlen", 40'(last_req_len), 40'(8));
`endif

    // Reset in the middle of a register access with no ack pending
    @(negedge clk);
    i_cmd = 6'd52; i_cmd_arg = 32'h1000_2000; i_cmd_crc_good_stb = 1'b1; i_cmd_stb = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0; i_cmd_crc_good_stb = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_req_pre", 40'(o_reg_req), 40'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state", 40'({o_reg_req, o_data_activate, o_rsps_stb, o_card_state}), 40'(0));
    rst = 1'b0;
    do_cmd("cmd3_rst", 6'd3, 32'h0, 1'b1, 1'b1, 2, frame(6'd3, 32'h0001_0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdio_cmd_sequencer.md
Name: sdio_cmd_sequencer

Overview:
- Command-layer controller above the SDIO device PHY.
- Consumes each decoded command strobe and its CRC verdict, tracks card state (INIT/STBY/CMD/TRN) and RCA.
- Performs CMD52 register accesses over a function register port and launches CMD53 byte transfers on the data PHY.
- Returns the response word, or a fail, to the PHY's response handshake.

Parameters:
- NUM_FUNCS, 1, highest valid I/O function number (1..7); function 0 = CIA.
- OCR, 24'hFF8000, OCR field returned in R4.
- RCA_SEED, 16'h0001, first RCA issued by CMD3.
- REG_TIMEOUT, 255, register-ack timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  SDIO clock, same as the PHY.
- rst  in  1  synchronous, active-high reset.
- i_cmd_stb  in  1  PHY command strobe.
- i_cmd_crc_good_stb  in  1  same-cycle CRC-good qualifier.
- i_cmd  in  6  command index.
- i_cmd_arg  in  32  command argument.
- o_rsps_stb  out  1  response-valid pulse to PHY.
- o_rsps  out  40  {dir=0, index[5:0], payload[31:0], 1'b0}.
- o_rsps_len  out  8  constant 8'd39.
- o_rsps_fail  out  1  pulse: no response for this command.
- o_reg_req  out  1  register request (level).
- o_reg_wr  out  1  request is a write.
- o_reg_func  out  3  function number.
- o_reg_addr  out  17  register address.
- o_reg_wdata  out  8  write data.
- i_reg_ack  in  1  register access complete.
- i_reg_rdata  in  8  read data, valid with ack.
- o_data_activate  out  1  data PHY enable.
- o_write_flag  out  1  1 = host-to-card.
- o_data_count  out  13  byte count.
- i_data_done  in  1  pulse: data transfer finished.
- o_card_state  out  2  00 INIT, 01 STBY, 10 CMD, 11 TRN.

Behaviour:
- Reset values: all outputs 0 except o_rsps_len = 39; card state INIT; RCA = RCA_SEED; sticky flags cleared.
- FSM states: IDLE, DECODE, REG_ACC, RSPS, XFER.
- IDLE: on i_cmd_stb, latch cmd, arg and crc_good, then go to DECODE. i_cmd_stb in any other state is ignored.
- DECODE (1 cycle), CRC bad: pulse o_rsps_fail, set sticky COM_CRC_ERR, go to IDLE.
- DECODE, CMD0: card state to INIT; pulse fail (no response).
- DECODE, CMD5: R4 payload {C=1, NF=NUM_FUNCS, MP=0, 3'b0, OCR}; legal in INIT/STBY only.
- DECODE, CMD3: legal in INIT/STBY. R6 payload {RCA, 16'h0000}; card state to STBY. RCA increments after each CMD3, skipping 0.
- DECODE, CMD7: arg[31:16] == RCA moves to CMD and sends R1b (payload 32'h0000_0000 with state bits). Non-matching RCA moves to STBY and pulses fail.
- DECODE, CMD52/53: legal only in CMD or TRN state.
- DECODE, function field > NUM_FUNCS: R5 with FUNC_NUM flag; no side effects.
- DECODE, CMD53 with block mode (arg[27]): R5 with ERROR flag.
- DECODE, any other index or illegal state: pulse fail, set sticky ILLEGAL.
- REG_ACC (CMD52): drive o_reg_req=1, o_reg_wr=arg[31], func=arg[30:28], addr=arg[25:9], wdata=arg[7:0]. Hold until i_reg_ack, then drop req the next cycle and capture i_reg_rdata.
- REG_ACC, RAW=1 write: return the ack data. Plain write: return wdata.
- R5 payload: {16'h0, flags[7:0], data[7:0]}. flags = {COM_CRC_ERR, ILLEGAL, IO_STATE[1:0], ERROR, 1'b0, FUNC_NUM, OUT_OF_RANGE}; IO_STATE = 01 in CMD, 10 in TRN. Sticky flags clear once reported.
- RSPS: o_rsps_stb high exactly one cycle. Minimum latency is i_cmd_stb to o_rsps_stb = 2 cycles, never fewer, because the PHY enters its wait state one cycle after its strobe.
- CMD53 byte mode, after RSPS: o_write_flag=arg[31]; o_data_count = arg[8:0], with 0 meaning 512; o_data_activate asserted the cycle after o_rsps_stb; card state TRN.
- XFER: hold outputs until i_data_done, then drop activate, card state to CMD, go to IDLE.
- Fail and stb are never asserted in the same cycle.
- rst at any time aborts immediately: req and activate drop next edge.

Optional Feature:
- Macro: SDIO_CMD_REG_TIMEOUT_EN.
- Defined: a counter in REG_ACC increments each cycle. On reaching REG_TIMEOUT, drop o_reg_req and respond R5 with ERROR=1, data 8'h00. A late i_reg_ack is ignored.
- Undefined: REG_ACC waits for ack indefinitely; no counter logic.

Decomposition:
- Shared package sdio_defines: command indices (CMD0/3/5/7/52/53), R5 flag bit positions, card-state encodings, argument field bit ranges, RSPS_LEN=39.
- Sub-module sdio_rsps_builder (combinational): index, type, fields → 40-bit o_rsps.

Test Plan:
- CMD5 arg 0, CRC good → after 2 cycles o_rsps_stb; o_rsps[38:33]=6'd5; payload 32'h90FF8000 with NUM_FUNCS=1.
- CMD3 then CMD7 arg 32'h0001_0000 → R6 RCA 16'h0001; R1b; o_card_state=2'b10.
- CMD52 read, func 1, addr 17'h00010, ack after 5 cycles with rdata 8'hA5 → reg_req high 5 cycles; R5 data=8'hA5, IO_STATE=01.
- Bad CRC on CMD52 → o_rsps_fail pulse, no reg_req; next good CMD52 R5 shows COM_CRC_ERR=1; a following CMD52 shows 0.
- CMD53 write, byte mode, count 0 → R5, then activate=1, write_flag=1, count=512; i_data_done → activate=0, state CMD.
- Timeout macro on, REG_TIMEOUT=8, no ack → req drops after 8 cycles; R5 ERROR=1, data 00.
